alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter: W, default 16, operand/result width in bits.
REQ-002 Parameter: DEPTH, default 2, result buffer entries; fixed at 2, other values unsupported.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 in_valid  input  1  command present on op/i0/i1.
REQ-006 in_ready  output  1  block can accept a command this cycle.
REQ-007 op  input  2  00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-008 i0  input  W  first operand.
REQ-009 i1  input  W  second operand.
REQ-010 out_valid  output  1  result at head of buffer is valid.
REQ-011 out_ready  input  1  consumer takes head result this cycle.
REQ-012 o  output  W  result at buffer head.
REQ-013 cout  output  1  carry flag at buffer head.
REQ-014 res_cnt  output  16  completed-result counter; present only with ALU_PIPE_STATS_EN.

Function
REQ-015 Command accepted on a rising edge when in_valid and in_ready are both 1; accepted command captured in stage-1 register (s1).
REQ-016 Cycle after capture, s1 result computed and written to the buffer tail; out_valid rises 2 edges after acceptance when the buffer was empty.
REQ-017 ADD: o = (i0+i1) mod 2^W; cout = carry out of bit W-1.
REQ-018 SUB: o = (i0 + ~i1 + 1) mod 2^W; cout = carry out of that sum (1 = no borrow).
REQ-019 AND/OR: o = bitwise i0&i1 or i0|i1; cout = 0.
REQ-020 in_ready = 1 when (buffer count + s1 occupied) < DEPTH; registered-state function only, no combinational path from out_ready.
REQ-021 Pop on edge when out_valid and out_ready; o/cout show next entry or hold last value when empty.
REQ-022 Simultaneous push and pop with count = DEPTH-1 or DEPTH: count unchanged, order preserved.
REQ-023 Results leave strictly in acceptance order; none dropped or duplicated under any out_ready pattern.
REQ-024 out_ready ignored when out_valid = 0; in_valid ignored when in_ready = 0.
REQ-025 Buffer read/write pointers wrap modulo DEPTH.

Reset
REQ-026 On reset assert: s1 empty, buffer count 0, pointers 0, out_valid 0, in_ready 1 after deassert, o 0, cout 0, res_cnt 0.
REQ-027 Reset asserted mid-operation discards s1 and all buffered results; no result from before reset ever appears at output.
REQ-028 First acceptance possible on the first rising edge with reset low.

Configuration
REQ-029 Macro ALU_PIPE_STATS_EN defined: res_cnt port exists, increments by 1 on every pop, wraps 16'hffff -> 0.
REQ-030 Macro undefined: res_cnt port and counter absent; all other behaviour identical.

Structure
REQ-031 Shared package alu_pkg holds op encodings (OP_ADD, OP_SUB, OP_AND, OP_OR) and W default.
REQ-032 Combinational datapath in one sub-module alu_core (op, i0, i1 -> o, cout); alu_pipe instantiates it between s1 and buffer.

Verification
REQ-033 out_ready=1; ADD aa55+55aa -> o ffff, cout 0, out_valid 2 edges after accept.
REQ-034 ADD ffff+0001 -> o 0000, cout 1; SUB 0001-7fff -> o 8002, cout 0; SUB 0000-0000 -> o 0000, cout 1.
REQ-035 AND aa55,55aa -> 0000 cout 0; OR aa55,55aa -> ffff cout 0.
REQ-036 out_ready=0, in_valid held with 3 distinct commands -> 2 accepted, in_ready 0; raise out_ready -> results out in order, third accepted after first pop.
REQ-037 2 results buffered, assert reset 1 ns off-edge -> out_valid 0 immediately; after release, next command's result is the only output.
REQ-038 With ALU_PIPE_STATS_EN: 16 pops -> res_cnt 16; preload near wrap -> ffff then 0000.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the pipelined ALU.
//   OP_ADD / OP_SUB / OP_AND / OP_OR : 2-bit command encodings on the op port
//   W_DEFAULT                        : default operand/result width
package alu_pkg;

   localparam int W_DEFAULT = 16;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_AND = 2'b10,
      OP_OR  = 2'b11
   } op_e;

endpackage : alu_pkg

// File: rtl/alu_core.sv
// alu_core -- purely combinational ALU datapath.
// Ports:
//   op   in  2  command (alu_pkg::op_e encoding)
//   i0   in  W  first operand
//   i1   in  W  second operand
//   o    out W  result, modulo 2^W
//   cout out 1  carry out of bit W-1 for ADD/SUB (SUB: 1 = no borrow), 0 otherwise
module alu_core
   import alu_pkg::*;
#(
   parameter int W = W_DEFAULT
) (
   input  logic [1:0]   op,
   input  logic [W-1:0] i0,
   input  logic [W-1:0] i1,
   output logic [W-1:0] o,
   output logic         cout
);

   logic [W:0] sum;

   always_comb begin
      sum  = '0;
      o    = '0;
      cout = 1'b0;
      case (op_e'(op))
         OP_ADD: begin
            sum  = {1'b0, i0} + {1'b0, i1};
            o    = sum[W-1:0];
            cout = sum[W];
         end
         OP_SUB: begin
            // Two's-complement subtract so the carry reads as "no borrow".
            sum  = {1'b0, i0} + {1'b0, ~i1} + {{W{1'b0}}, 1'b1};
            o    = sum[W-1:0];
            cout = sum[W];
         end
         OP_AND:  o = i0 & i1;
         OP_OR:   o = i0 | i1;
         default: o = '0;
      endcase
   end

endmodule : alu_core

// File: rtl/alu_pipe.sv
// alu_pipe -- two-stage ALU: command register (s1) feeding a 2-entry result FIFO.
// Ports:
//   clk        in   1  clock, rising edge
//   reset      in   1  asynchronous active-high reset
//   in_valid   in   1  command present on op/i0/i1
//   in_ready   out  1  command can be accepted this cycle
//   op         in   2  00 ADD, 01 SUB, 10 AND, 11 OR
//   i0, i1     in   W  operands
//   out_valid  out  1  result at buffer head is valid
//   out_ready  in   1  consumer takes head result this cycle
//   o          out  W  result at buffer head (last popped value when empty)
//   cout       out  1  carry flag at buffer head
//   res_cnt    out 16  popped-result counter (only with ALU_PIPE_STATS_EN)
// Optional feature macro: ALU_PIPE_STATS_EN adds the res_cnt port and counter.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int W     = W_DEFAULT,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [1:0]   op,
   input  logic [W-1:0] i0,
   input  logic [W-1:0] i1,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] o,
   output logic         cout
`ifdef ALU_PIPE_STATS_EN
   ,
   output logic [15:0]  res_cnt
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW:0] DEPTH_V = (CW + 1)'(DEPTH);

   // Stage 1: accepted command
   logic          s1_vld_q, s1_vld_d;
   logic [1:0]    s1_op_q;
   logic [W-1:0]  s1_a_q, s1_b_q;

   // Stage 2: result buffer; entries are {cout, o}
   logic [W:0]    mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W:0]    hold_q, hold_d;

   logic [W-1:0]  core_o;
   logic          core_c;
   logic [CW:0]   occ;
   logic          accept, push, pop;

   alu_core #(.W(W)) u_core (
      .op   (s1_op_q),
      .i0   (s1_a_q),
      .i1   (s1_b_q),
      .o    (core_o),
      .cout (core_c)
   );

   // Occupancy counts the in-flight s1 command so a push always finds room;
   // in_ready depends only on registered state.
   always_comb begin
      occ      = {1'b0, cnt_q} + {{CW{1'b0}}, s1_vld_q};
      in_ready = (occ < DEPTH_V);
      out_valid = (cnt_q != '0);
      accept   = in_valid && in_ready;
      push     = s1_vld_q;
      pop      = out_valid && out_ready;
   end

   always_comb begin
      s1_vld_d = accept;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      hold_d   = hold_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         hold_d   = mem_q[rd_ptr_q];
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_vld_q <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         hold_q   <= '0;
      end else begin
         s1_vld_q <= s1_vld_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         hold_q   <= hold_d;
      end
   end

   // Data registers carry no reset; validity is tracked by s1_vld_q / cnt_q.
   always_ff @(posedge clk) begin
      if (accept) begin
         s1_op_q <= op;
         s1_a_q  <= i0;
         s1_b_q  <= i1;
      end
      if (push) mem_q[wr_ptr_q] <= {core_c, core_o};
   end

   // When empty the output shows the last popped result (0 after reset).
   always_comb begin
      if (out_valid) begin
         o    = mem_q[rd_ptr_q][W-1:0];
         cout = mem_q[rd_ptr_q][W];
      end else begin
         o    = hold_q[W-1:0];
         cout = hold_q[W];
      end
   end

`ifdef ALU_PIPE_STATS_EN
   logic [15:0] res_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)    res_cnt_q <= '0;
      else if (pop) res_cnt_q <= res_cnt_q + 16'd1;
   end

   assign res_cnt = res_cnt_q;
`endif

endmodule : alu_pipe

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe -- scoreboard bench for alu_pipe (W = 16).
// Driver pushes expected {cout, o} when a command is accepted; a negedge
// monitor pops and compares on every out_valid && out_ready.
// Build with ALU_PIPE_STATS_EN defined to also exercise res_cnt.
module tb_alu_pipe;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  op;
   logic [15:0] i0, i1;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] o;
   logic        cout;
`ifdef ALU_PIPE_STATS_EN
   logic [15:0] res_cnt;
`endif

   int tests = 0;
   int fails = 0;
   int pops  = 0;
   bit rnd   = 1'b0;
   logic [16:0] exp_q[$];
   logic [16:0] last_res = '0;

   always #5 clk = ~clk;

   alu_pipe #(.W(16), .DEPTH(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .i0        (i0),
      .i1        (i1),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .o         (o),
      .cout      (cout)
`ifdef ALU_PIPE_STATS_EN
      ,
      .res_cnt   (res_cnt)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s got %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: results from integer arithmetic on the operand values.
   function automatic logic [16:0] model(input logic [1:0] c, input logic [15:0] a, input logic [15:0] b);
      int unsigned ua, ub, r;
      ua = a;
      ub = b;
      case (c)
         2'd0: begin r = ua + ub; return {(r > 32'd65535), r[15:0]}; end
         2'd1: begin r = (ua + 32'd65536 - ub) % 32'd65536; return {(ua >= ub), r[15:0]}; end
         2'd2: return {1'b0, a & b};
         default: return {1'b0, a | b};
      endcase
   endfunction

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic issue(input logic [1:0] c, input logic [15:0] a, input logic [15:0] b);
      int n;
      n = 0;
      in_valid = 1'b1;
      op = c;
      i0 = a;
      i1 = b;
      forever begin
         if (rnd) out_ready = 1'($urandom_range(0, 1));
         if (in_ready) begin
            exp_q.push_back(model(c, a, b));
            @(posedge clk); #1;
            break;
         end
         @(posedge clk); #1;
         n++;
         if (n > 100) begin
            chk("accept_timeout", 32'(n), 32'd0);
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      out_ready = 1'b1;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL pop_unexpected got %h required no result at %0t", {cout, o}, $time);
         end else begin
            logic [16:0] e;
            e = exp_q.pop_front();
            chk("result_o", 32'(o), 32'(e[15:0]));
            chk("result_cout", 32'(cout), 32'(e[16]));
            last_res = e;
            pops++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got running required finished");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      in_valid = 1'b0;
      op = 2'd0;
      i0 = '0;
      i1 = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_o", 32'(o), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);

      // Latency: s1 occupied after accept, result visible after the next edge.
      issue(2'd0, 16'haa55, 16'h55aa);
      chk("lat_vld_e1", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      chk("lat_vld_e2", 32'(out_valid), 32'd1);
      chk("lat_o", 32'(o), 32'h0000ffff);
      chk("lat_cout", 32'(cout), 32'd0);
      drain();

      issue(2'd0, 16'hffff, 16'h0001);
      issue(2'd1, 16'h0001, 16'h7fff);
      issue(2'd1, 16'h0000, 16'h0000);
      issue(2'd2, 16'haa55, 16'h55aa);
      issue(2'd3, 16'haa55, 16'h55aa);
      drain();
      repeat (2) @(posedge clk); #1;
      chk("hold_vld", 32'(out_valid), 32'd0);
      chk("hold_o", 32'(o), 32'(last_res[15:0]));

      // Back-pressure: two accepted, third waits for the first pop.
      out_ready = 1'b0;
      issue(2'd0, 16'h1111, 16'h2222);
      issue(2'd1, 16'h5000, 16'h6000);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      in_valid = 1'b1;
      op = 2'd3;
      i0 = 16'h0f00;
      i1 = 16'h00f0;
      repeat (3) @(posedge clk); #1;
      chk("bp_in_ready_hold", 32'(in_ready), 32'd0);
      chk("bp_head_o", 32'(o), 32'h00003333);
      chk("bp_qsize", 32'(exp_q.size()), 32'd2);
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_ready_after_pop", 32'(in_ready), 32'd1);
      issue(2'd3, 16'h0f00, 16'h00f0);
      drain();

      // Reset with two results buffered.
      out_ready = 1'b0;
      issue(2'd0, 16'h0101, 16'h0202);
      issue(2'd2, 16'hf0f0, 16'hff00);
      @(posedge clk); #1;
      chk("pre_rst_vld", 32'(out_valid), 32'd1);
      reset = 1'b1;
      #1;
      chk("mid_rst_vld", 32'(out_valid), 32'd0);
      chk("mid_rst_o", 32'(o), 32'd0);
      chk("mid_rst_cout", 32'(cout), 32'd0);
      exp_q.delete();
      pops = 0;
      last_res = '0;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("post_rst_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      issue(2'd1, 16'h0010, 16'h0020);
      drain();
      repeat (4) @(posedge clk); #1;
      chk("post_rst_pops", 32'(pops), 32'd1);
      chk("post_rst_idle", 32'(out_valid), 32'd0);

      // Randomised traffic with random consumer stalls.
      rnd = 1'b1;
      for (int k = 0; k < 300; k++) begin
         logic [15:0] a, b;
         a = 16'($urandom);
         b = 16'($urandom);
         if (k % 17 == 0) a = 16'hffff;
         if (k % 19 == 0) b = 16'h0000;
         if ($urandom_range(0, 3) == 0) begin
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
         end
         issue(2'($urandom_range(0, 3)), a, b);
      end
      rnd = 1'b0;
      drain();

`ifdef ALU_PIPE_STATS_EN
      chk("res_cnt", 32'(res_cnt), 32'(pops[15:0]));
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_alu_pipe
